// File: rtl/bcd_to_bin_seq_if.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq_if
// Bundle of request/response signals for the sequential BCD-to-binary
// converter. Clock and reset are not part of the bundle.
//
// Parameters:
//   DIGITS  number of packed BCD digits on d
//   BW      width of the binary result
//
// Signals:
//   start  request a conversion, d is captured on the same edge
//   d      packed BCD input, digit 0 in d[3:0]
//   busy   conversion in progress
//   done   one-cycle pulse, bin/err valid
//   bin    binary result, held until the next completion
//   err    invalid-digit flag
//
// Modports:
//   master  drives start/d, observes the results (requester side)
//   slave   the converter itself
// ---------------------------------------------------------------------------
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 2,
    parameter int BW     = 7
);
    logic                  start;
    logic [4*DIGITS-1:0]   d;
    logic                  busy;
    logic                  done;
    logic [BW-1:0]         bin;
    logic                  err;

    modport master (
        output start,
        output d,
        input  busy,
        input  done,
        input  bin,
        input  err
    );

    modport slave (
        input  start,
        input  d,
        output busy,
        output done,
        output bin,
        output err
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
// Sequential packed-BCD to binary converter using reverse double-dabble,
// one bit per clock. A DIGITS-digit word takes N = 4*DIGITS shift cycles;
// DONE pulses for one cycle after the N-th shift.
//
// Parameters:
//   DIGITS  number of BCD digits (default 2)
//   BW      binary result width, 2**BW > 10**DIGITS - 1 (default 7)
//
// Ports:
//   clk_i   clock, all state changes on the rising edge
//   rst_i   synchronous active-high reset, overrides start
//   bus     bcd_to_bin_seq_if.slave: start, d in; busy, done, bin, err out
//
// Optional feature (macro BCD_CHECK_EN):
//   when defined, a start whose input contains a digit above 9 skips the
//   shift phase, returns bin=0 with err=1 one cycle later; a valid start
//   clears err. When undefined, err is tied to 0 and no digit check is made.
// ---------------------------------------------------------------------------
module bcd_to_bin_seq #(
    parameter int DIGITS = 2,
    parameter int BW     = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bcd_to_bin_seq_if.slave   bus
);

    localparam int N  = 4 * DIGITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    bcd_q, bcd_d;
    logic [N-1:0]    binReg_q, binReg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   binOut_q, binOut_d;

    logic [2*N-1:0]  shiftAll;
    logic [N-1:0]    shiftBcd;
    logic [N-1:0]    shiftBin;

`ifdef BCD_CHECK_EN
    logic            err_q, err_d;

    function automatic logic hasBadDigit(input logic [N-1:0] word);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (word[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction
`endif

    // One reverse double-dabble step: shift the concatenated register right,
    // then pull every digit that now reads 8 or more back down by 3. This
    // undoes the halving of the tens weight that the shift applied to it.
    always_comb begin
        shiftAll = {bcd_q, binReg_q} >> 1;
        shiftBcd = shiftAll[2*N-1:N];
        shiftBin = shiftAll[N-1:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (shiftBcd[4*i +: 4] >= 4'd8) begin
                shiftBcd[4*i +: 4] = shiftBcd[4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state and datapath updates. IDLE and FIN both accept a start so
    // that results can be produced back to back; starts seen during SHIFT
    // are dropped. The visible result is only updated when the last shift
    // lands, so bin stays stable across a following conversion.
    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        binReg_d = binReg_q;
        cnt_d    = cnt_q;
        binOut_d = binOut_q;
`ifdef BCD_CHECK_EN
        err_d    = err_q;
`endif

        case (state_q)
            IDLE, FIN: begin
                if (bus.start) begin
`ifdef BCD_CHECK_EN
                    if (hasBadDigit(bus.d)) begin
                        state_d  = FIN;
                        binOut_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        state_d  = SHIFT;
                        bcd_d    = bus.d;
                        binReg_d = '0;
                        cnt_d    = '0;
                        err_d    = 1'b0;
                    end
`else
                    state_d  = SHIFT;
                    bcd_d    = bus.d;
                    binReg_d = '0;
                    cnt_d    = '0;
`endif
                end else if (state_q == FIN) begin
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                bcd_d    = shiftBcd;
                binReg_d = shiftBin;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = FIN;
                    binOut_d = shiftBin[BW-1:0];
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset during a
    // conversion simply discards it, so no done is ever produced for it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            bcd_q    <= '0;
            binReg_q <= '0;
            cnt_q    <= '0;
            binOut_q <= '0;
`ifdef BCD_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            binReg_q <= binReg_d;
            cnt_q    <= cnt_d;
            binOut_q <= binOut_d;
`ifdef BCD_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == FIN);
    assign bus.bin  = binOut_q;
`ifdef BCD_CHECK_EN
    assign bus.err  = err_q;
`else
    assign bus.err  = 1'b0;
`endif

endmodule
